// File: rtl/trans_id_allocator_if.sv
// Allocation/release bundle for trans_id_allocator.
// master = issue/commit side, slave = allocator.
interface trans_id_allocator_if #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned NR_ISSUE   = 2,
  parameter int unsigned NR_COMMIT  = 2
);
  localparam int unsigned IdW  = $clog2(NR_ENTRIES);
  localparam int unsigned CntW = $clog2(NR_ENTRIES + 1);

  logic                        flush_i;
  logic [NR_ISSUE-1:0]         alloc_req_i;
  logic [NR_ISSUE-1:0]         alloc_gnt_o;
  logic [NR_ISSUE*IdW-1:0]     alloc_id_o;
  logic [NR_COMMIT-1:0]        commit_ack_i;
  logic [NR_COMMIT*IdW-1:0]    commit_id_o;
  logic [CntW-1:0]             count_o;
  logic                        full_o;
  logic                        empty_o;

  modport master (
    output flush_i,
    output alloc_req_i,
    output commit_ack_i,
    input  alloc_gnt_o,
    input  alloc_id_o,
    input  commit_id_o,
    input  count_o,
    input  full_o,
    input  empty_o
  );

  modport slave (
    input  flush_i,
    input  alloc_req_i,
    input  commit_ack_i,
    output alloc_gnt_o,
    output alloc_id_o,
    output commit_id_o,
    output count_o,
    output full_o,
    output empty_o
  );
endinterface

// File: rtl/trans_id_allocator.sv
// Multi-port in-order trans-ID allocator: NR_ISSUE grants and NR_COMMIT releases per cycle.
// Define TRANS_ID_ALLOC_BYPASS_EN to let IDs released this cycle be granted in the same cycle.
module trans_id_allocator #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned NR_ISSUE   = 2,
  parameter int unsigned NR_COMMIT  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  trans_id_allocator_if.slave   bus
);
  localparam int unsigned IdW   = $clog2(NR_ENTRIES);
  localparam int unsigned CntW  = $clog2(NR_ENTRIES + 1);
  // One extra bit so free slots plus same-cycle releases never overflow.
  localparam int unsigned FreeW = CntW + 1;

  logic [IdW-1:0]       issue_ptr_q, issue_ptr_d;
  logic [IdW-1:0]       commit_ptr_q, commit_ptr_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [FreeW-1:0]     free;
  logic [FreeW-1:0]     n_alloc;
  logic [FreeW-1:0]     n_commit;
  logic [NR_ISSUE-1:0]  gnt;
  logic                 chain;
  logic [NR_COMMIT-1:0] ack_plus_one;

  always_comb begin
    n_commit = '0;
    for (int k = 0; k < NR_COMMIT; k++) begin
      n_commit = n_commit + FreeW'(bus.commit_ack_i[k]);
    end
  end

`ifdef TRANS_ID_ALLOC_BYPASS_EN
  assign free = FreeW'(NR_ENTRIES) - FreeW'(count_q) + n_commit;
`else
  assign free = FreeW'(NR_ENTRIES) - FreeW'(count_q);
`endif

  // Grants form a contiguous run from port 0: a port is only served if all lower ports are.
  always_comb begin
    gnt   = '0;
    chain = rst_ni & ~bus.flush_i;
    for (int k = 0; k < NR_ISSUE; k++) begin
      gnt[k] = chain & bus.alloc_req_i[k] & (free > FreeW'(k));
      chain  = gnt[k];
    end
  end

  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < NR_ISSUE; k++) begin
      n_alloc = n_alloc + FreeW'(gnt[k]);
    end
  end

  always_comb begin
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;
    if (bus.flush_i) begin
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end else begin
      issue_ptr_d  = issue_ptr_q + IdW'(n_alloc);
      commit_ptr_d = commit_ptr_q + IdW'(n_commit);
      count_d      = CntW'(FreeW'(count_q) + n_alloc - n_commit);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    bus.alloc_id_o = '0;
    for (int k = 0; k < NR_ISSUE; k++) begin
      bus.alloc_id_o[k*IdW +: IdW] = issue_ptr_q + IdW'(k);
    end
  end

  always_comb begin
    bus.commit_id_o = '0;
    for (int k = 0; k < NR_COMMIT; k++) begin
      bus.commit_id_o[k*IdW +: IdW] = commit_ptr_q + IdW'(k);
    end
  end

  assign bus.alloc_gnt_o = gnt;
  assign bus.count_o     = count_q;
  assign bus.full_o      = (count_q == CntW'(NR_ENTRIES));
  assign bus.empty_o     = (count_q == '0);

  // A legal ack vector is a run of ones from bit 0, so adding one clears every set bit.
  assign ack_plus_one = bus.commit_ack_i + NR_COMMIT'(1);

  ack_contiguous: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.commit_ack_i & ack_plus_one) == '0);

  ack_within_count: assert property (@(posedge clk_i) disable iff (!rst_ni || bus.flush_i)
    n_commit <= FreeW'(count_q));

  count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(NR_ENTRIES));

  // Full wraps the pointer difference to zero, so only the low IdW bits of count compare.
  ptr_count_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
    IdW'(count_q) == IdW'(issue_ptr_q - commit_ptr_q));

endmodule

// File: tb/tb_trans_id_allocator.sv
// Bench for trans_id_allocator (NR_ENTRIES=8, 2 issue, 2 commit ports).
// Follows TRANS_ID_ALLOC_BYPASS_EN when the DUT is built with it.
module tb_trans_id_allocator;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  trans_id_allocator_if #(.NR_ENTRIES(8), .NR_ISSUE(2), .NR_COMMIT(2)) bus ();

  trans_id_allocator #(.NR_ENTRIES(8), .NR_ISSUE(2), .NR_COMMIT(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    int cnt;
    int id0;
    int cid0;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] req;
    logic [1:0] ack;
    logic [1:0] gnt;
    int         id0;
    int         cnt;
  } vec_t;
  vec_t vecs[9];

  int m_issue, m_commit, m_count;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    bus.flush_i = 1'b0;
    bus.commit_ack_i = 2'b00;
    bus.alloc_req_i = 2'b11;
    #1;
    check("rst_gnt", int'(bus.alloc_gnt_o), 0);
    check("rst_count", int'(bus.count_o), 0);
    check("rst_full", int'(bus.full_o), 0);
    check("rst_empty", int'(bus.empty_o), 1);
    check("rst_alloc_id1", int'(bus.alloc_id_o[5:3]), 1);
    check("rst_commit_id1", int'(bus.commit_id_o[5:3]), 1);
    bus.alloc_req_i = 2'b00;
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_issue = 0;
    m_commit = 0;
    m_count = 0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, push the post-edge
  // expectation, then pop and check it just after the rising edge.
  task automatic drive(input logic [1:0] req, input logic [1:0] ack, input logic flush,
                       output logic [1:0] gnt_seen, output int id_seen);
    int nfree, lead, ng, nc;
    logic [1:0] egnt;
    exp_t e;
    @(negedge clk_i);
    bus.alloc_req_i = req;
    bus.commit_ack_i = ack;
    bus.flush_i = flush;
    #1;
    nc = (ack == 2'b11) ? 2 : ((ack == 2'b01) ? 1 : 0);
    nfree = 8 - m_count;
`ifdef TRANS_ID_ALLOC_BYPASS_EN
    nfree = nfree + nc;
`endif
    lead = req[0] ? (req[1] ? 2 : 1) : 0;
    ng = flush ? 0 : ((lead < nfree) ? lead : nfree);
    egnt = (ng == 2) ? 2'b11 : ((ng == 1) ? 2'b01 : 2'b00);
    check("gnt", int'(bus.alloc_gnt_o), int'(egnt));
    check("alloc_id0", int'(bus.alloc_id_o[2:0]), m_issue);
    check("alloc_id1", int'(bus.alloc_id_o[5:3]), (m_issue + 1) % 8);
    check("commit_id0", int'(bus.commit_id_o[2:0]), m_commit);
    check("commit_id1", int'(bus.commit_id_o[5:3]), (m_commit + 1) % 8);
    gnt_seen = bus.alloc_gnt_o;
    id_seen = int'(bus.alloc_id_o[2:0]);
    if (flush) begin
      m_issue = 0;
      m_commit = 0;
      m_count = 0;
    end else begin
      m_issue = (m_issue + ng) % 8;
      m_commit = (m_commit + nc) % 8;
      m_count = m_count + ng - nc;
    end
    e.cnt = m_count;
    e.id0 = m_issue;
    e.cid0 = m_commit;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    bus.alloc_req_i = 2'b00;
    bus.commit_ack_i = 2'b00;
    bus.flush_i = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("count", int'(bus.count_o), e.cnt);
      check("full", int'(bus.full_o), (e.cnt == 8) ? 1 : 0);
      check("empty", int'(bus.empty_o), (e.cnt == 0) ? 1 : 0);
      check("next_alloc_id0", int'(bus.alloc_id_o[2:0]), e.id0);
      check("next_commit_id0", int'(bus.commit_id_o[2:0]), e.cid0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    int id;

    bus.flush_i = 1'b0;
    bus.alloc_req_i = 2'b00;
    bus.commit_ack_i = 2'b00;

    // req, ack, gnt, alloc_id0 before edge, count after edge
    vecs[0] = '{2'b10, 2'b00, 2'b00, 0, 0};
    vecs[1] = '{2'b11, 2'b00, 2'b11, 0, 2};
    vecs[2] = '{2'b11, 2'b00, 2'b11, 2, 4};
    vecs[3] = '{2'b11, 2'b00, 2'b11, 4, 6};
    vecs[4] = '{2'b11, 2'b00, 2'b11, 6, 8};
    vecs[5] = '{2'b11, 2'b00, 2'b00, 0, 8};
    vecs[6] = '{2'b00, 2'b01, 2'b00, 0, 7};
    vecs[7] = '{2'b11, 2'b00, 2'b01, 0, 8};
`ifdef TRANS_ID_ALLOC_BYPASS_EN
    vecs[8] = '{2'b01, 2'b11, 2'b01, 1, 7};
`else
    vecs[8] = '{2'b01, 2'b11, 2'b00, 1, 6};
`endif

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].req, vecs[i].ack, 1'b0, g, id);
      check($sformatf("vec%0d_gnt", i), int'(g), int'(vecs[i].gnt));
      check($sformatf("vec%0d_id0", i), id, vecs[i].id0);
      check($sformatf("vec%0d_count", i), int'(bus.count_o), vecs[i].cnt);
    end

    // Wrap-around: 10 allocs and 10 commits leave both pointers at 2.
    do_reset();
    drive(2'b11, 2'b00, 1'b0, g, id);
    for (int i = 0; i < 4; i++) drive(2'b11, 2'b11, 1'b0, g, id);
    drive(2'b00, 2'b11, 1'b0, g, id);
    check("wrap_empty", int'(bus.empty_o), 1);
    check("wrap_commit_ptr", int'(bus.commit_id_o[2:0]), 2);
    drive(2'b11, 2'b00, 1'b0, g, id);
    check("wrap_first_id", id, 2);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 1'b0, g, id);
      check($sformatf("wrap_id_%0d", i), id, (4 + 2 * i) % 8);
    end

    // Flush with count=5 and a simultaneous ack.
    do_reset();
    drive(2'b11, 2'b00, 1'b0, g, id);
    drive(2'b11, 2'b00, 1'b0, g, id);
    drive(2'b01, 2'b00, 1'b0, g, id);
    check("pre_flush_count", int'(bus.count_o), 5);
    drive(2'b11, 2'b01, 1'b1, g, id);
    check("flush_gnt", int'(g), 0);
    check("flush_count", int'(bus.count_o), 0);
    check("flush_alloc_id0", int'(bus.alloc_id_o[2:0]), 0);
    check("flush_empty", int'(bus.empty_o), 1);

    // Asynchronous reset between edges with count=3.
    do_reset();
    drive(2'b11, 2'b00, 1'b0, g, id);
    drive(2'b01, 2'b00, 1'b0, g, id);
    check("pre_rst_count", int'(bus.count_o), 3);
    bus.alloc_req_i = 2'b11;
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_count", int'(bus.count_o), 0);
    check("async_empty", int'(bus.empty_o), 1);
    check("async_gnt", int'(bus.alloc_gnt_o), 0);
    check("async_alloc_id0", int'(bus.alloc_id_o[2:0]), 0);
    check("async_commit_id0", int'(bus.commit_id_o[2:0]), 0);
    bus.alloc_req_i = 2'b00;
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_issue = 0;
    m_commit = 0;
    m_count = 0;
    drive(2'b01, 2'b00, 1'b0, g, id);
    check("post_rst_id", id, 0);
    check("post_rst_gnt", int'(g), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trans_id_allocator.md
Name: trans_id_allocator

Overview:
- Multi-port in-order transaction-ID allocator for the scoreboard.
- Hands out trans IDs to up to NR_ISSUE instructions per cycle and retires up to NR_COMMIT per cycle, oldest first.
- Generalises the fixed single-issue ID counter to match the derived NrIssuePorts, NrCommitPorts and NR_SB_ENTRIES configuration.
- Sits between the issue stage (allocation) and the commit stage (release).

Parameters:
- NR_ENTRIES, 8, number of trans IDs (NR_SB_ENTRIES); power of two, ≥2
- NR_ISSUE, 2, allocation ports (NrIssuePorts), 1..4
- NR_COMMIT, 2, release ports (NrCommitPorts), 1..4
- IdW, $clog2(NR_ENTRIES), trans ID width (TRANS_ID_BITS); derived, not overridable
- CntW, $clog2(NR_ENTRIES+1), occupancy width; derived

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all in-flight IDs
- alloc_req_i  in  NR_ISSUE  per-port allocation request
- alloc_gnt_o  out  NR_ISSUE  per-port grant (combinational)
- alloc_id_o  out  NR_ISSUE*IdW  ID offered to each port
- commit_ack_i  in  NR_COMMIT  release oldest IDs; must be contiguous from bit 0
- commit_id_o  out  NR_COMMIT*IdW  IDs next in line for release
- count_o  out  CntW  IDs in flight
- full_o  out  1  count_o == NR_ENTRIES
- empty_o  out  1  count_o == 0

Behaviour:
- State: issue_ptr (IdW), commit_ptr (IdW), count (CntW). Reset value of all three is 0.
- Outputs at reset: alloc_gnt_o=0, alloc_id_o[k]=k, commit_id_o[k]=k, count_o=0, full_o=0, empty_o=1.
- alloc_id_o[k] = issue_ptr + k, mod NR_ENTRIES. commit_id_o[k] = commit_ptr + k, mod NR_ENTRIES. Pointers wrap naturally at IdW bits.
- Grant rule (in-order, no holes): alloc_gnt_o[k] = alloc_req_i[k] & (k==0 | alloc_gnt_o[k-1]) & (free > k), where free = NR_ENTRIES − count.
  - A request on port k with port k−1 not granted is never granted.
  - Grants are combinational, zero latency; the ID is consumed at the clock edge.
- Let nA = number of grants and nC = number of acks. At each edge:
  - issue_ptr += nA
  - commit_ptr += nC
  - count += nA − nC
- Default (macro off): free is computed from the pre-commit count, so IDs released this cycle are reusable next cycle.
- Simultaneous alloc and commit when full: no grant that cycle; count drops by nC.
- flush_i has highest priority:
  - grants forced to 0 that cycle
  - next state: issue_ptr=commit_ptr=count=0; acks that cycle are ignored
- Reset mid-operation: state returns asynchronously to reset values; no grant while rst_ni low.
- Illegal inputs (flagged by simulation assertions; RTL behaviour is don't-care):
  - nC > count
  - non-contiguous commit_ack_i (e.g. 2'b10)
  - count exceeding NR_ENTRIES
- Assertion (always holds): count_o == (issue_ptr − commit_ptr) mod NR_ENTRIES, or NR_ENTRIES when full.

Optional Feature:
- Macro: TRANS_ID_ALLOC_BYPASS_EN
- Defined: free = NR_ENTRIES − count + nC. IDs released by commit_ack_i are grantable in the same cycle. Adds a combinational path commit_ack_i → alloc_gnt_o.
- Undefined: no ack→grant path. Free slots use the registered count only.

Test Plan:
- Reset, NR_ENTRIES=8, NR_ISSUE=2, NR_COMMIT=2:
  - req=2'b11 for 4 cycles → IDs (0,1),(2,3),(4,5),(6,7)
  - then full_o=1, count_o=8
  - next cycle req=2'b11 → gnt=2'b00
- count=7, req=2'b11 → gnt=2'b01, single ID issued; full_o=1 next cycle.
- full, ack=2'b11, req=2'b01:
  - macro off → gnt=0, count→6
  - macro on → gnt=2'b01, count→7
- Wrap-around:
  - after 10 allocs and 10 commits, issue_ptr=commit_ptr=2, empty_o=1
  - req=2'b11 → IDs (2,3)
  - 6 more allocs → IDs wrap 7→0→1 in order
- Gating and flush:
  - req=2'b10 (port 0 idle) → gnt=2'b00
  - flush_i with count=5 and ack=2'b01 → next cycle count_o=0, alloc_id_o[0]=0, empty_o=1
- Async reset:
  - rst_ni dropped mid-burst (count=3), between clock edges → outputs immediately at reset values
  - first alloc after release gets ID 0
